sim_run_monitor: RTL and testbench



---
 rtl/sim_run_monitor.sv | 138 +++++++++++++
 tb/tb_sim_run_monitor.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_monitor.sv
// Run controller for riscv_top: reset hold, cycle/char statistics, halt, watchdog.
// Optional stall detection is built when RUN_MON_STALL_DETECT_EN is defined.
module sim_run_monitor #(
  parameter int unsigned RST_CYCLES  = 25,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 2500000,
  parameter logic [31:0] CHAR_ADDR   = 32'h0003_0000,
  parameter logic [31:0] HALT_ADDR   = 32'h0003_0004,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_we,
  input  logic [31:0]      io_addr,
  input  logic [7:0]       io_wdata,
  input  logic             activity,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic             stalled,
  output logic [7:0]       exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] char_count
);

  localparam int unsigned RstEff = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
  localparam int unsigned HoldW  = $clog2(RstEff + 1);
  localparam logic [HoldW-1:0] HoldLast   = HoldW'(RstEff - 1);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    StHold,
    StRun,
    StDone,
    StTout
`ifdef RUN_MON_STALL_DETECT_EN
    , StStall
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] char_q, char_d;
  logic [7:0]       exit_q, exit_d;
  logic             char_hit, halt_hit;

  assign char_hit = io_we && (io_addr == CHAR_ADDR);
  assign halt_hit = io_we && (io_addr == HALT_ADDR);

`ifdef RUN_MON_STALL_DETECT_EN
  logic [31:0] idle_q, idle_d;
`else
  logic unused_activity;
  assign unused_activity = activity;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cycle_d = cycle_q;
    char_d  = char_q;
    exit_d  = exit_q;
`ifdef RUN_MON_STALL_DETECT_EN
    idle_d  = idle_q;
`endif
    unique case (state_q)
      StHold: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HoldLast) state_d = StRun;
      end
      StRun: begin
        if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
        if (char_hit && (char_q != '1)) char_d = char_q + 1'b1;
`ifdef RUN_MON_STALL_DETECT_EN
        idle_d = (activity || char_hit || halt_hit) ? '0 : idle_q + 1'b1;
`endif
        // Halt beats timeout beats stall when they land on the same edge.
        if (halt_hit) begin
          exit_d  = io_wdata;
          state_d = StDone;
        end else if ((TIMEOUT != 0) && (cycle_d == TimeoutCnt)) begin
          state_d = StTout;
        end
`ifdef RUN_MON_STALL_DETECT_EN
        else if (idle_d == STALL_LIMIT) begin
          state_d = StStall;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHold;
      hold_q   <= '0;
      cycle_q  <= '0;
      char_q   <= '0;
      exit_q   <= '0;
      core_rst <= 1'b1;
      running  <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cycle_q  <= cycle_d;
      char_q   <= char_d;
      exit_q   <= exit_d;
      core_rst <= (state_d != StRun);
      running  <= (state_d == StRun);
      done     <= (state_d == StDone);
      timeout  <= (state_d == StTout);
    end
  end

`ifdef RUN_MON_STALL_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q  <= '0;
      stalled <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      stalled <= (state_d == StStall);
    end
  end
`else
  assign stalled = 1'b0;
`endif

  assign exit_code   = exit_q;
  assign cycle_count = cycle_q;
  assign char_count  = char_q;

endmodule

// File: tb/tb_sim_run_monitor.sv
// Randomized self-checking bench for sim_run_monitor; two instances share stimulus,
// one with the default watchdog and one with TIMEOUT=50.
module tb_sim_run_monitor;

  localparam int RST  = 25;
  localparam int TO_A = 2500000;
  localparam int TO_B = 50;
  localparam int SL   = 8;
  localparam logic [31:0] CHAR = 32'h0003_0000;
  localparam logic [31:0] HALT = 32'h0003_0004;
  localparam logic [76:0] RstVec = {1'b1, 76'b0};
`ifdef RUN_MON_STALL_DETECT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, io_we = 1'b0, activity = 1'b1;
  logic [31:0] io_addr = '0;
  logic [7:0]  io_wdata = '0;

  logic core_rst_a, running_a, done_a, timeout_a, stalled_a;
  logic core_rst_b, running_b, done_b, timeout_b, stalled_b;
  logic [7:0]  exit_a, exit_b;
  logic [31:0] cyc_a, chr_a, cyc_b, chr_b;
  logic [76:0] obs_a, obs_b;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: edges with rst low, whether the run ended and how (1 halt, 2 timeout, 3 stall).
  int          m_low[2];
  bit          m_end[2];
  int          m_kind[2];
  longint      m_cyc[2], m_chr[2];
  logic [7:0]  m_ex[2];
  int          m_idle[2];

  always #5 clk = ~clk;

  sim_run_monitor #(.RST_CYCLES(RST), .TIMEOUT(TO_A), .STALL_LIMIT(SL)) dut_a (
    .clk(clk), .rst(rst), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .activity(activity), .core_rst(core_rst_a), .running(running_a), .done(done_a),
    .timeout(timeout_a), .stalled(stalled_a), .exit_code(exit_a), .cycle_count(cyc_a),
    .char_count(chr_a)
  );

  sim_run_monitor #(.RST_CYCLES(RST), .TIMEOUT(TO_B), .STALL_LIMIT(SL)) dut_b (
    .clk(clk), .rst(rst), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .activity(activity), .core_rst(core_rst_b), .running(running_b), .done(done_b),
    .timeout(timeout_b), .stalled(stalled_b), .exit_code(exit_b), .cycle_count(cyc_b),
    .char_count(chr_b)
  );

  assign obs_a = {core_rst_a, running_a, done_a, timeout_a, stalled_a, exit_a, cyc_a, chr_a};
  assign obs_b = {core_rst_b, running_b, done_b, timeout_b, stalled_b, exit_b, cyc_b, chr_b};

  function automatic void model_step(int i, int to);
    bit accepted;
    if (rst) begin
      m_low[i] = 0; m_end[i] = 0; m_kind[i] = 0;
      m_cyc[i] = 0; m_chr[i] = 0; m_ex[i] = '0; m_idle[i] = 0;
    end else if (!m_end[i]) begin
      if (m_low[i] >= RST) begin
        m_cyc[i]++;
        if (io_we && io_addr == CHAR) m_chr[i]++;
        accepted = io_we && (io_addr == CHAR || io_addr == HALT);
        m_idle[i] = (activity || accepted) ? 0 : m_idle[i] + 1;
        if (io_we && io_addr == HALT) begin
          m_ex[i] = io_wdata; m_end[i] = 1; m_kind[i] = 1;
        end else if (to != 0 && m_cyc[i] == longint'(to)) begin
          m_end[i] = 1; m_kind[i] = 2;
        end else if (StallEn && m_idle[i] == SL) begin
          m_end[i] = 1; m_kind[i] = 3;
        end
      end else begin
        m_low[i]++;
      end
    end
  endfunction

  function automatic logic [76:0] exp_vec(int i);
    bit run;
    run = !m_end[i] && (m_low[i] >= RST);
    return {!run, run, m_end[i] && m_kind[i] == 1, m_end[i] && m_kind[i] == 2,
            m_end[i] && m_kind[i] == 3, m_ex[i], 32'(m_cyc[i]), 32'(m_chr[i])};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, TO_A);
    model_step(1, TO_B);
    #1;
  endtask

  task automatic set_io(bit we, logic [31:0] a, logic [7:0] d);
    io_we = we; io_addr = a; io_wdata = d;
  endtask

  // Reset for one edge, then sit out the hold so the next tick is run cycle 1.
  task automatic go_run();
    set_io(0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (RST) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_io(1, HALT, 8'h55);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if (obs_a !== RstVec || obs_a !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL reset_values k=%0d: got %h want %h", k, obs_a, RstVec);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= RST; k++) begin
      tick();
      n_cmp++;
      if (obs_a !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d: got %h want %h", k, obs_a, exp_vec(0));
      end
      if (k >= RST - 1) begin
        n_cmp++;
        if ({core_rst_a, running_a} !== ((k == RST) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL hold_edge k=%0d: got core_rst/running %b%b", k, core_rst_a, running_a);
        end
      end
    end
    set_io(0, '0, '0);
  endtask

  task automatic test_chars_halt();
    logic [76:0] want;
    activity = 1'b1;
    go_run();
    for (int n = 1; n <= 100; n++) begin
      if (n == 10 || n == 20 || n == 30) set_io(1, CHAR, 8'h41);
      else if (n == 100) set_io(1, HALT, 8'h2A);
      else set_io(0, '0, '0);
      tick();
      n_cmp++;
      if (obs_a !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL chars_halt n=%0d: got %h want %h", n, obs_a, exp_vec(0));
      end
    end
    set_io(0, '0, '0);
    want = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2A, 32'd100, 32'd3};
    n_cmp++;
    if (obs_a !== want) begin
      n_fail++;
      $display("FAIL halt_result: got %h want %h", obs_a, want);
    end
    for (int n = 0; n < 50; n++) begin
      set_io(n[0], (n % 3 == 0) ? CHAR : HALT, 8'(n));
      tick();
    end
    set_io(0, '0, '0);
    n_cmp++;
    if (obs_a !== want) begin
      n_fail++;
      $display("FAIL halt_frozen: got %h want %h", obs_a, want);
    end
  endtask

  task automatic test_watchdog();
    activity = 1'b1;
    go_run();
    for (int n = 1; n <= 60; n++) begin
      tick();
      n_cmp++;
      if (obs_b !== exp_vec(1)) begin
        n_fail++;
        $display("FAIL watchdog n=%0d: got %h want %h", n, obs_b, exp_vec(1));
      end
      if (n == 49 || n == 50 || n == 60) begin
        n_cmp++;
        if (timeout_b !== (n >= 50) || done_b !== 1'b0 || cyc_b !== 32'(n > 50 ? 50 : n)) begin
          n_fail++;
          $display("FAIL watchdog_edge n=%0d: got timeout=%b done=%b cyc=%0d", n, timeout_b,
                   done_b, cyc_b);
        end
      end
    end
  endtask

  task automatic test_halt_timeout();
    logic [7:0] code;
    code = 8'($urandom);
    activity = 1'b1;
    go_run();
    repeat (49) tick();
    set_io(1, HALT, code);
    tick();
    set_io(0, '0, '0);
    n_cmp++;
    if (done_b !== 1'b1 || timeout_b !== 1'b0 || exit_b !== code || cyc_b !== 32'd50) begin
      n_fail++;
      $display("FAIL halt_vs_timeout: got done=%b timeout=%b exit=%h cyc=%0d want 1 0 %h 50",
               done_b, timeout_b, exit_b, cyc_b, code);
    end
  endtask

  task automatic test_mid_reset();
    activity = 1'b1;
    go_run();
    repeat (39) begin
      set_io(1, CHAR, 8'h30);
      tick();
    end
    set_io(0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (obs_a !== RstVec || obs_b !== RstVec) begin
      n_fail++;
      $display("FAIL mid_reset: got a=%h b=%h want %h", obs_a, obs_b, RstVec);
    end
    for (int k = 1; k <= RST; k++) begin
      tick();
      n_cmp++;
      if (obs_a !== exp_vec(0) || running_a !== (k == RST)) begin
        n_fail++;
        $display("FAIL mid_reset_hold k=%0d: got %h want %h", k, obs_a, exp_vec(0));
      end
    end
  endtask

  task automatic test_stall();
    activity = 1'b1;
    go_run();
    activity = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      n_cmp++;
      if (obs_a !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL stall n=%0d: got %h want %h", n, obs_a, exp_vec(0));
      end
    end
    n_cmp++;
`ifdef RUN_MON_STALL_DETECT_EN
    if (stalled_a !== 1'b1 || running_a !== 1'b0 || cyc_a !== 32'd8) begin
      n_fail++;
      $display("FAIL stall_detect: got stalled=%b running=%b cyc=%0d want 1 0 8", stalled_a,
               running_a, cyc_a);
    end
`else
    if (stalled_a !== 1'b0 || running_a !== 1'b1 || cyc_a !== 32'd20) begin
      n_fail++;
      $display("FAIL stall_absent: got stalled=%b running=%b cyc=%0d want 0 1 20", stalled_a,
               running_a, cyc_a);
    end
`endif
    activity = 1'b1;
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(199) == 0) || (m_end[0] && m_end[1] && $urandom_range(9) == 0);
      activity = ($urandom_range(3) != 0);
      sel = $urandom_range(9);
      if ($urandom_range(3) != 0) set_io(0, 32'($urandom), 8'($urandom));
      else if (sel < 5) set_io(1, CHAR, 8'($urandom));
      else if (sel == 5) set_io(1, HALT, 8'($urandom));
      else if (sel == 6) set_io(1, CHAR ^ (32'd1 << $urandom_range(31)), 8'($urandom));
      else set_io(1, 32'($urandom), 8'($urandom));
      tick();
      n_cmp++;
      if (obs_a !== exp_vec(0) || obs_b !== exp_vec(1)) begin
        n_fail++;
        $display("FAIL random n=%0d: got a=%h b=%h want a=%h b=%h", n, obs_a, obs_b,
                 exp_vec(0), exp_vec(1));
      end
    end
    rst = 1'b0;
    set_io(0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_low[i] = 0; m_end[i] = 0; m_kind[i] = 0;
      m_cyc[i] = 0; m_chr[i] = 0; m_ex[i] = '0; m_idle[i] = 0;
    end
    test_reset();
    test_chars_halt();
    test_watchdog();
    test_halt_timeout();
    test_mid_reset();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
